lms_tap_reader: RTL

Read-out side of the LMS adaptive FIR: it captures the filter's parallel tap vector (f_0..f_{L-1}) on a software or periodic trigger and streams it out as a framed, flow-controlled word sequence (header, L taps, checksum). It sits between the adaptive FIR tap outputs and the host/monitor capture path. It is the reader for the coefficients the filter writes every cycle.

---
 rtl/lms_pkg.sv | 20 ++
 rtl/lms_period_timer.sv | 38 +++
 rtl/lms_tap_reader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lms_pkg.sv
// Shared constants and types for the LMS adaptive FIR and its tap reader.
//   LMS_L      : default number of filter taps
//   LMS_W_TAP  : default tap word width (signed two's complement)
//   HDR_MAGIC  : magic byte placed in the top 8 bits of every frame header
//   rd_state_e : tap reader frame state
package lms_pkg;

   localparam int LMS_L = 16;
   localparam int LMS_W_TAP = 16;

   localparam logic [7:0] HDR_MAGIC = 8'hA5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      TAPS   = 2'd2,
      CHECK  = 2'd3
   } rd_state_e;

endpackage

// File: rtl/lms_period_timer.sv
// Periodic auto-capture tick generator.
//   clk       : system clock
//   reset     : synchronous active-high reset
//   period_in : tick period in cycles; 0 disables the timer
//   tick      : registered one-cycle pulse, once every period_in cycles
module lms_period_timer
   import lms_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] period_in,
   output logic        tick
);

   logic [15:0] count_q;
   logic        tick_q;

   // >= rather than == so that lowering period_in below the running count
   // wraps on the very next cycle instead of counting through 2^16.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else if (period_in == 16'd0) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else if (count_q >= period_in - 16'd1) begin
         count_q <= '0;
         tick_q  <= 1'b1;
      end else begin
         count_q <= count_q + 16'd1;
         tick_q  <= 1'b0;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/lms_tap_reader.sv
// Captures the LMS filter tap vector on a software or periodic trigger and
// streams it as a framed valid/ready word sequence:
//   header {HDR_MAGIC, seq}, tap 0 .. tap L-1, checksum (mod 2^W_TAP sum).
//
// state  | meaning
// IDLE   | no frame; waiting for a trigger
// HEADER | header word presented (m_first=1)
// TAPS   | snapshot word idx presented
// CHECK  | checksum word presented (m_last=1)
//
// Ports:
//   clk, reset         : system clock, synchronous active-high reset
//   tap_in             : flattened taps, tap k at [k*W_TAP +: W_TAP]
//   snap_req           : single-cycle capture request
//   period_in          : auto-capture period in cycles, 0 disables
//   clr_ovr            : clears the sticky overrun flag
//   m_ready            : downstream ready
//   m_valid/m_data     : output word and its valid
//   m_first/m_last     : header / checksum word markers
//   busy               : frame in progress
//   overrun            : sticky, a trigger was dropped during a frame
module lms_tap_reader
   import lms_pkg::*;
#(
   parameter int L     = LMS_L,
   parameter int W_TAP = LMS_W_TAP
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [L*W_TAP-1:0] tap_in,
   input  logic               snap_req,
   input  logic [15:0]        period_in,
   input  logic               clr_ovr,
   input  logic               m_ready,
   output logic               m_valid,
   output logic [W_TAP-1:0]   m_data,
   output logic               m_first,
   output logic               m_last,
   output logic               busy,
   output logic               overrun
);

   localparam int IDX_W = $clog2(L);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(L - 1);

   rd_state_e        state_q;
   logic [IDX_W-1:0] idx_q;
   logic [W_TAP-1:0] csum_q;
   logic [7:0]       seq_q;
   logic [W_TAP-1:0] snap_q [L];
   logic             m_valid_q;
   logic [W_TAP-1:0] m_data_q;
   logic             m_first_q;
   logic             m_last_q;
   logic             ovr_q;

   logic             tick;
   logic             trig_d;
   logic             xfer_d;
   logic             cap_d;
   logic             drop_d;
   logic [IDX_W-1:0] idx_d;
   logic [W_TAP-1:0] csum_d;
   logic [W_TAP-1:0] hdr_d;

   lms_period_timer u_timer (
      .clk       (clk),
      .reset     (reset),
      .period_in (period_in),
      .tick      (tick)
   );

   assign trig_d = snap_req | tick;
   assign xfer_d = m_valid_q & m_ready;
   // A trigger is taken when idle, or when it lands on the final (checksum)
   // transfer so that frames can run back to back with no idle cycle.
   assign cap_d  = trig_d & ((state_q == IDLE) | ((state_q == CHECK) & xfer_d));
   assign drop_d = trig_d & (state_q != IDLE) & ~cap_d;
   assign idx_d  = idx_q + IDX_W'(1);
   // m_data_q holds snap_q[idx_q] throughout TAPS, so it is the word being summed.
   assign csum_d = csum_q + m_data_q;
   assign hdr_d  = (W_TAP'(HDR_MAGIC) << (W_TAP - 8)) | W_TAP'(seq_q);

   // Snapshot is pure datapath: every tap is loaded on the same edge.
   always_ff @(posedge clk) begin
      if (cap_d) begin
         for (int k = 0; k < L; k++) begin
            snap_q[k] <= tap_in[k*W_TAP +: W_TAP];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         csum_q    <= '0;
         seq_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_first_q <= 1'b0;
         m_last_q  <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         if (drop_d) begin
            ovr_q <= 1'b1;
         end else if (clr_ovr) begin
            ovr_q <= 1'b0;
         end

         if (cap_d) begin
            state_q   <= HEADER;
            seq_q     <= seq_q + 8'd1;
            m_valid_q <= 1'b1;
            m_data_q  <= hdr_d;
            m_first_q <= 1'b1;
            m_last_q  <= 1'b0;
         end else begin
            case (state_q)
               HEADER: begin
                  if (xfer_d) begin
                     state_q   <= TAPS;
                     idx_q     <= '0;
                     csum_q    <= '0;
                     m_data_q  <= snap_q[0];
                     m_first_q <= 1'b0;
                  end
               end
               TAPS: begin
                  if (xfer_d) begin
                     csum_q <= csum_d;
                     if (idx_q == IDX_LAST) begin
                        state_q  <= CHECK;
                        m_data_q <= csum_d;
                        m_last_q <= 1'b1;
                     end else begin
                        idx_q    <= idx_d;
                        m_data_q <= snap_q[idx_d];
                     end
                  end
               end
               CHECK: begin
                  if (xfer_d) begin
                     state_q   <= IDLE;
                     m_valid_q <= 1'b0;
                     m_last_q  <= 1'b0;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_first = m_first_q;
   assign m_last  = m_last_q;
   assign busy    = (state_q != IDLE);
   assign overrun = ovr_q;

endmodule
